// File: rtl/sdx_axi_mem_responder.sv
// sdx_axi_mem_responder: AXI4 INCR burst responder over a byte-writable word memory (AW/W/B and AR/R slave channels, burst counters, sticky wlast error)
module sdx_axi_mem_responder #(
  parameter int C_S_AXI_ADDR_WIDTH = 64,
  parameter int C_S_AXI_DATA_WIDTH = 512,
  parameter int C_MEM_DEPTH = 256
) (
  input  logic                            ap_clk,
  input  logic                            ap_rst_n,
  input  logic                            s_axi_awvalid,
  output logic                            s_axi_awready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [7:0]                      s_axi_awlen,
  input  logic                            s_axi_wvalid,
  output logic                            s_axi_wready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                            s_axi_wlast,
  output logic                            s_axi_bvalid,
  input  logic                            s_axi_bready,
  input  logic                            s_axi_arvalid,
  output logic                            s_axi_arready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [7:0]                      s_axi_arlen,
  output logic                            s_axi_rvalid,
  input  logic                            s_axi_rready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
  output logic                            s_axi_rlast,
  output logic [31:0]                     wr_burst_count,
  output logic [31:0]                     rd_burst_count,
  output logic                            err_wlast
);
  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int OW = $clog2(DW / 8);
  localparam int IW = $clog2(C_MEM_DEPTH);
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_t;
  typedef enum logic {R_IDLE, R_DATA} r_t;
  w_t ws, ws_n;
  r_t rs, rs_n;
  logic live;
  logic [IW-1:0] widx, ridx;
  logic [7:0] wcnt;
  logic [8:0] rleft;
  logic [DW-1:0] mem [C_MEM_DEPTH];
  logic [DW-1:0] rd_q;
  logic p_valid, p_last;
  logic [DW:0] b0, b1, pd, hd;
  logic [1:0] c;
  logic aw_hs, w_hs, b_hs, ar_hs, pop, pop_f, push, iss;
  logic unused_addr_bits;
  assign unused_addr_bits = ^{s_axi_awaddr, s_axi_araddr};
  always_comb begin
    s_axi_awready = live && ws == W_IDLE;
    s_axi_wready = ws == W_DATA;
    s_axi_bvalid = ws == W_RESP;
    s_axi_arready = live && rs == R_IDLE;
    aw_hs = s_axi_awvalid && s_axi_awready;
    w_hs = s_axi_wvalid && s_axi_wready;
    b_hs = s_axi_bvalid && s_axi_bready;
    ar_hs = s_axi_arvalid && s_axi_arready;
    pd = {p_last, rd_q};
    hd = c != 2'd0 ? b0 : pd;
    s_axi_rvalid = c != 2'd0 || p_valid;
    s_axi_rdata = s_axi_rvalid ? hd[DW-1:0] : '0;
    s_axi_rlast = s_axi_rvalid && hd[DW];
    pop = s_axi_rvalid && s_axi_rready;
    pop_f = pop && c != 2'd0;
    push = p_valid && !(pop && c == 2'd0);
    // issue only if the beat still fits in the buffer even when the sink stalls next cycle
    iss = rs == R_DATA && rleft != 9'd0 && ({1'b0, c} + {2'b0, p_valid} - {2'b0, pop}) <= 3'd1;
    ws_n = aw_hs ? W_DATA : w_hs && wcnt == 8'd0 ? W_RESP : b_hs ? W_IDLE : ws;
    rs_n = ar_hs ? R_DATA : pop && s_axi_rlast ? R_IDLE : rs;
  end
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      ws <= W_IDLE;
      rs <= R_IDLE;
      live <= 1'b0;
    end else begin
      ws <= ws_n;
      rs <= rs_n;
      live <= 1'b1;
    end
  end
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      c <= 2'd0;
      p_valid <= 1'b0;
      p_last <= 1'b0;
      rleft <= 9'd0;
      err_wlast <= 1'b0;
      wr_burst_count <= 32'd0;
      rd_burst_count <= 32'd0;
    end else begin
      c <= c + {1'b0, push} - {1'b0, pop_f};
      p_valid <= iss;
      p_last <= iss && rleft == 9'd1;
      rleft <= ar_hs ? {1'b0, s_axi_arlen} + 9'd1 : iss ? rleft - 9'd1 : rleft;
      if (w_hs && s_axi_wlast != (wcnt == 8'd0)) err_wlast <= 1'b1;
      if (b_hs) wr_burst_count <= wr_burst_count + 32'd1;
      if (pop && s_axi_rlast) rd_burst_count <= rd_burst_count + 32'd1;
    end
  end
  always_ff @(posedge ap_clk) begin
    rd_q <= mem[ridx];
    widx <= aw_hs ? s_axi_awaddr[OW +: IW] : w_hs ? widx + 1'b1 : widx;
    wcnt <= aw_hs ? s_axi_awlen : w_hs ? wcnt - 8'd1 : wcnt;
    ridx <= ar_hs ? s_axi_araddr[OW +: IW] : iss ? ridx + 1'b1 : ridx;
    b0 <= pop_f ? (c == 2'd2 ? b1 : pd) : (c == 2'd0 ? pd : b0);
    if (push && c == (pop_f ? 2'd2 : 2'd1)) b1 <= pd;
    for (int i = 0; i < DW / 8; i++)
      if (w_hs && s_axi_wstrb[i]) mem[widx][8*i +: 8] <= s_axi_wdata[8*i +: 8];
  end
endmodule

// File: tb/tb_sdx_axi_mem_responder.sv
// tb_sdx_axi_mem_responder: directed self-checking bench for sdx_axi_mem_responder
module tb_sdx_axi_mem_responder;
  localparam int AW = 64;
  localparam int DW = 512;
  localparam int SW = DW / 8;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic awvalid = 1'b0, awready, wvalid = 1'b0, wready, wlast = 1'b0, bvalid, bready = 1'b0;
  logic arvalid = 1'b0, arready, rvalid, rready = 1'b0, rlast, err;
  logic [AW-1:0] awaddr = '0, araddr = '0;
  logic [7:0] awlen = '0, arlen = '0;
  logic [DW-1:0] wdata = '0, rdata;
  logic [SW-1:0] wstrb = '0;
  logic [31:0] wcount, rcount;
  int checks = 0;
  int errors = 0;
  logic [DW-1:0] wd [256];
  logic [SW-1:0] ws [256];
  logic wl [256];
  logic [DW-1:0] got [256];
  logic lst [256];
  logic [DW-1:0] old20, old30, pat;
  sdx_axi_mem_responder dut (
    .ap_clk(clk), .ap_rst_n(rst_n),
    .s_axi_awvalid(awvalid), .s_axi_awready(awready), .s_axi_awaddr(awaddr), .s_axi_awlen(awlen),
    .s_axi_wvalid(wvalid), .s_axi_wready(wready), .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast),
    .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_arvalid(arvalid), .s_axi_arready(arready), .s_axi_araddr(araddr), .s_axi_arlen(arlen),
    .s_axi_rvalid(rvalid), .s_axi_rready(rready), .s_axi_rdata(rdata), .s_axi_rlast(rlast),
    .wr_burst_count(wcount), .rd_burst_count(rcount), .err_wlast(err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic wr_burst(input logic [AW-1:0] a, input int len);
    int n;
    awvalid = 1'b1;
    awaddr = a;
    awlen = len[7:0];
    n = 0;
    while (!awready && n < 50) begin
      step();
      n++;
    end
    chk("aw_timeout", n < 50, 1);
    step();
    awvalid = 1'b0;
    chk("aw_ready_after_hs", awready, 0);
    chk("w_ready_after_aw", wready, 1);
    for (int i = 0; i <= len; i++) begin
      wvalid = 1'b1;
      wdata = wd[i];
      wstrb = ws[i];
      wlast = wl[i];
      chk("w_ready_beat", wready, 1);
      step();
    end
    wvalid = 1'b0;
    wlast = 1'b0;
    chk("b_valid_after_last", bvalid, 1);
    chk("w_ready_after_last", wready, 0);
    bready = 1'b1;
    step();
    bready = 1'b0;
    chk("b_valid_after_hs", bvalid, 0);
    chk("aw_ready_after_b", awready, 1);
  endtask
  task automatic rd_burst(input logic [AW-1:0] a, input int len, input bit thr);
    int n, k, cyc;
    logic hv;
    logic [DW-1:0] hd;
    arvalid = 1'b1;
    araddr = a;
    arlen = len[7:0];
    n = 0;
    while (!arready && n < 50) begin
      step();
      n++;
    end
    chk("ar_timeout", n < 50, 1);
    step();
    arvalid = 1'b0;
    chk("ar_ready_after_hs", arready, 0);
    chk("r_valid_at_ar_plus1", rvalid, 0);
    k = 0;
    cyc = 0;
    hv = 1'b0;
    hd = '0;
    while (k <= len && cyc < 4000) begin
      rready = thr ? 1'($urandom_range(0, 1)) : 1'b1;
      if (hv) begin
        chk("r_hold_valid", rvalid, 1);
        chk("r_hold_data", rdata, hd);
      end
      hv = 1'b0;
      if (rvalid && rready) begin
        got[k] = rdata;
        lst[k] = rlast;
        k++;
      end else if (rvalid) begin
        hv = 1'b1;
        hd = rdata;
      end
      step();
      cyc++;
    end
    rready = 1'b0;
    chk("r_beat_count", k, len + 1);
    if (!thr) chk("r_burst_cycles", cyc, len + 2);
    chk("r_valid_after_burst", rvalid, 0);
    chk("ar_ready_after_burst", arready, 1);
  endtask
  initial begin
    repeat (3) step();
    chk("rst_awready", awready, 0);
    chk("rst_wready", wready, 0);
    chk("rst_bvalid", bvalid, 0);
    chk("rst_arready", arready, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_rlast", rlast, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_wcount", wcount, 0);
    chk("rst_rcount", rcount, 0);
    chk("rst_err", err, 0);
    rst_n = 1'b1;
    step();
    chk("awready_after_rst", awready, 1);
    chk("arready_after_rst", arready, 1);
    // single beat write/read at 0x40
    wd[0] = {64{8'hA5}};
    ws[0] = '1;
    wl[0] = 1'b1;
    wr_burst(64'h40, 0);
    chk("t1_wcount", wcount, 1);
    rd_burst(64'h40, 0, 0);
    chk("t1_rdata", got[0], {64{8'hA5}});
    chk("t1_rlast", lst[0], 1);
    chk("t1_rcount", rcount, 1);
    // 16-beat burst wrapping past the end of memory
    for (int i = 0; i < 16; i++) begin
      wd[i] = DW'(i);
      ws[i] = '1;
      wl[i] = (i == 15);
    end
    wr_burst(64'(250 * 64), 15);
    rd_burst(64'(250 * 64), 15, 0);
    for (int i = 0; i < 16; i++) begin
      chk("t2_rdata", got[i], DW'(i));
      chk("t2_rlast", lst[i], (i == 15));
    end
    rd_burst(64'h0, 0, 0);
    chk("t2_word0", got[0], 6);
    chk("t2_wcount", wcount, 2);
    chk("t2_rcount", rcount, 3);
    // partial strobes
    wd[0] = '1;
    ws[0] = '1;
    wl[0] = 1'b1;
    wr_burst(64'(5 * 64), 0);
    wd[0] = '0;
    ws[0] = 64'hF;
    wr_burst(64'(5 * 64), 0);
    rd_burst(64'(5 * 64), 0, 0);
    chk("t3_strobe", got[0], {{480{1'b1}}, 32'h0});
    // full-memory throttled read
    for (int i = 0; i < 256; i++) begin
      wd[i] = {16{i[31:0] ^ 32'h5A5A0000}};
      ws[i] = '1;
      wl[i] = (i == 255);
    end
    wr_burst(64'h0, 255);
    chk("t4_wcount", wcount, 5);
    rd_burst(64'h0, 255, 1);
    for (int i = 0; i < 256; i++) begin
      pat = {16{i[31:0] ^ 32'h5A5A0000}};
      chk("t4_rdata", got[i], pat);
      chk("t4_rlast", lst[i], (i == 255));
    end
    chk("t4_rcount", rcount, 5);
    // early wlast on beat 2 of 4
    chk("t5_err_before", err, 0);
    for (int i = 0; i < 4; i++) begin
      wd[i] = DW'(i + 100);
      ws[i] = '1;
      wl[i] = (i == 1);
    end
    wr_burst(64'(64 * 64), 3);
    chk("t5_err_set", err, 1);
    chk("t5_wcount", wcount, 6);
    wd[0] = DW'(77);
    wl[0] = 1'b1;
    wr_burst(64'(70 * 64), 0);
    chk("t5_err_sticky", err, 1);
    // concurrent same-word write and read: read-first
    old20 = {16{32'd20 ^ 32'h5A5A0000}};
    old30 = {16{32'd30 ^ 32'h5A5A0000}};
    wd[0] = {16{32'hDEADBEEF}};
    ws[0] = '1;
    wl[0] = 1'b1;
    fork
      wr_burst(64'(20 * 64), 0);
      rd_burst(64'(20 * 64), 0, 0);
    join
    chk("t6_read_first", got[0], old20);
    rd_burst(64'(20 * 64), 0, 0);
    chk("t6_new_data", got[0], {16{32'hDEADBEEF}});
    chk("t6_wcount", wcount, 8);
    chk("t6_rcount", rcount, 7);
    // reset in the middle of both bursts
    awvalid = 1'b1;
    awaddr = 64'(100 * 64);
    awlen = 8'd7;
    arvalid = 1'b1;
    araddr = 64'(30 * 64);
    arlen = 8'd7;
    step();
    awvalid = 1'b0;
    arvalid = 1'b0;
    wvalid = 1'b1;
    wdata = '1;
    wstrb = '1;
    wlast = 1'b0;
    rready = 1'b0;
    step();
    step();
    chk("t6_rvalid_midburst", rvalid, 1);
    rst_n = 1'b0;
    step();
    wvalid = 1'b0;
    rst_n = 1'b1;
    chk("t6_rst_rvalid", rvalid, 0);
    chk("t6_rst_bvalid", bvalid, 0);
    chk("t6_rst_wready", wready, 0);
    chk("t6_rst_awready", awready, 0);
    chk("t6_rst_wcount", wcount, 0);
    chk("t6_rst_rcount", rcount, 0);
    chk("t6_rst_err", err, 0);
    step();
    chk("t6_awready_back", awready, 1);
    chk("t6_arready_back", arready, 1);
    chk("t6_rvalid_idle", rvalid, 0);
    rd_burst(64'(20 * 64), 0, 0);
    chk("t6_mem_kept20", got[0], {16{32'hDEADBEEF}});
    rd_burst(64'(30 * 64), 0, 0);
    chk("t6_mem_kept30", got[0], old30);
    chk("t6_rcount_after", rcount, 2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sdx_axi_mem_responder.md
# sdx_axi_mem_responder

AXI4 memory-mapped responder (slave) that terminates the reduced m_axi signal set driven by our kernel masters: it accepts INCR write and read bursts and serves them from an internal byte-writable, word-addressed memory. It sits in the kernel simulation harness and in loopback builds in place of the platform DDR port, so kernels can be exercised with no shell. Write and read channels run as independent state machines, and the block keeps burst counters and a sticky protocol-error flag for checking.

## Interface
- C_S_AXI_ADDR_WIDTH, 64, byte address width
- C_S_AXI_DATA_WIDTH, 512, data width; power of two, 32..1024
- C_MEM_DEPTH, 256, memory depth in data words; power of two
- ap_clk  in  1  single clock; all logic rising-edge
- ap_rst_n  in  1  reset, synchronous, active-low
- s_axi_awvalid / s_axi_awready  in / out  1  write address handshake
- s_axi_awaddr  in  C_S_AXI_ADDR_WIDTH  burst start byte address
- s_axi_awlen  in  8  beats-1
- s_axi_wvalid / s_axi_wready  in / out  1  write data handshake
- s_axi_wdata  in  C_S_AXI_DATA_WIDTH  write data
- s_axi_wstrb  in  C_S_AXI_DATA_WIDTH/8  byte enables
- s_axi_wlast  in  1  last-beat marker (checked, not trusted)
- s_axi_bvalid / s_axi_bready  out / in  1  write response handshake (OKAY implied)
- s_axi_arvalid / s_axi_arready  in / out  1  read address handshake
- s_axi_araddr  in  C_S_AXI_ADDR_WIDTH  burst start byte address
- s_axi_arlen  in  8  beats-1
- s_axi_rvalid / s_axi_rready  out / in  1  read data handshake
- s_axi_rdata  out  C_S_AXI_DATA_WIDTH  read data
- s_axi_rlast  out  1  asserted on final read beat
- wr_burst_count  out  32  completed write bursts (B handshakes), wraps at 2^32
- rd_burst_count  out  32  completed read bursts (last R handshakes), wraps
- err_wlast  out  1  sticky: wlast mismatch seen

## Operation
- Word index = addr[log2(C_S_AXI_DATA_WIDTH/8) +: log2(C_MEM_DEPTH)]; byte-offset bits ignored (aligned bursts only); upper bits ignored, so addressing aliases modulo memory size.
- Beat n of a burst uses word (start index + n) mod C_MEM_DEPTH; bursts wrap at memory end without error.
- Write FSM: W_IDLE (awready=1) -> AW handshake latches index, beat counter=awlen -> W_DATA (wready=1); each W handshake writes bytes where wstrb=1, others retained; decrement counter -> after beat awlen+1 -> W_RESP (bvalid=1, held until bready) -> W_IDLE.
- Burst length is governed by awlen only. wlast=1 on a non-final beat or wlast=0 on the final beat sets err_wlast; the burst still ends after awlen+1 beats.
- Read FSM: R_IDLE (arready=1) -> AR handshake latches index/count -> R_DATA: memory read has one cycle registered latency; a two-entry output buffer keeps one beat per cycle while rready=1 and holds rdata/rlast/rvalid stable while rready=0. rlast=1 only on beat arlen+1. After the final R handshake -> R_IDLE.
- Channels are independent: a read and a write can be in flight together. On a same-word read and write in the same cycle, the read returns the old data (read-first).
- Reset: both FSMs go to IDLE, the output buffer is emptied, counters and err_wlast are cleared; memory contents are not cleared. Reset mid-burst abandons the burst silently.

## Timing
- Reset values: awready=0, wready=0, bvalid=0, arready=0, rvalid=0, rlast=0, rdata=0, counters=0, err_wlast=0. awready and arready rise in the first cycle after ap_rst_n is sampled high.
- AW handshake at cycle T: awready=0 and wready=1 from T+1.
- Last W handshake at T: wready=0 and bvalid=1 from T+1. B handshake at T: bvalid=0, awready=1 and wr_burst_count+1 visible from T+1.
- AR handshake at T: arready=0 from T+1; first rvalid=1 at T+2. With rready held 1, the burst completes at T+2+arlen.
- Final R handshake at T: rvalid=0, arready=1 and rd_burst_count+1 visible from T+1.
- Minimum turnaround: awlen=0 write = 3 cycles AW-to-AW; arlen=0 read = 3 cycles AR-to-AR.

## Test plan
- Single write awaddr=0x40, awlen=0, wdata=0xA5.., wstrb=all-ones, then read same address -> bvalid 1 cycle after the W beat; rdata=0xA5.. with rlast=1 at AR+2; both counters=1.
- 16-beat write at word 250 (C_MEM_DEPTH=256) with data=beat index, then 16-beat read -> words 250..255 and 0..9 hold 0..15; read returns 0..15 in order, one beat per cycle, rlast only on beat 16.
- Partial strobes: write all-ones, then write zeros with wstrb=0x...0F -> readback has low 4 bytes zero, rest 0xFF.
- Random rready throttling (about 50%) on a 256-beat read -> no beat dropped or duplicated; rdata stable whenever rvalid=1 and rready=0.
- wlast asserted on beat 2 of an awlen=3 burst -> err_wlast=1 and stays 1; wready stays high for 4 beats; bvalid follows the 4th beat.
- Concurrent write and read bursts to the same word, then ap_rst_n low for one cycle mid-burst -> the overlapping read returns pre-write data; after reset all valids are 0, counters 0, awready/arready 1, and earlier memory contents are preserved.
